// File: rtl/result_bcd_converter.sv
// Result-to-BCD converter: captures the arithmetic unit's result and converts its magnitude to packed BCD.
// Latency: done pulses RW+1 edges after the accepting edge; the error path takes 1 edge.
// No backpressure: start is ignored while busy, and outputs hold until the next FINISH.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits with 4'hF.
module result_bcd_converter #(
   parameter int WORD_LENGTH = 16,
   parameter int DIGITS      = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [2*WORD_LENGTH-1:0]   Data,
   input  logic                       op,
   input  logic                       error_in,
   output logic                       busy,
   output logic                       done,
   output logic                       valid,
   output logic [4*DIGITS-1:0]        BCD,
   output logic                       sign,
   output logic                       error_out
);

   localparam int RW = 2 * WORD_LENGTH;
   localparam int CW = $clog2(RW + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

   state_t         state;
   logic [RW-1:0]  mag;
   logic [BW-1:0]  work_bcd;
   logic [CW-1:0]  cnt;
   logic           err_cap;
   logic [BW-1:0]  adj_bcd;
   logic [BW-1:0]  final_bcd;

   // Add 3 to every working digit that is 5 or more, ahead of the shift.
   always_comb begin
      adj_bcd = work_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_bcd[4*i +: 4] >= 4'd5) begin
            adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic nz;

   // Replace leading zero digits above digit 0 with the blank code; blank all digits on error.
   always_comb begin
      final_bcd = work_bcd;
      nz        = 1'b0;
      if (err_cap) begin
         final_bcd = '1;
      end else begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            nz = nz | (work_bcd[4*i +: 4] != 4'd0);
            if (!nz) begin
               final_bcd[4*i +: 4] = 4'hF;
            end
         end
      end
   end
`else
   // Plain BCD; the working register is already cleared on the error path.
   assign final_bcd = work_bcd;
`endif

   // Control FSM with the double-dabble datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mag       <= '0;
         work_bcd  <= '0;
         cnt       <= '0;
         err_cap   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         BCD       <= '0;
         sign      <= 1'b0;
         error_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  valid    <= 1'b0;
                  busy     <= 1'b1;
                  work_bcd <= '0;
                  cnt      <= '0;
                  err_cap  <= error_in;
                  if (error_in) begin
                     error_out <= 1'b1;
                     sign      <= 1'b0;
                     BCD       <= '0;
                     mag       <= '0;
                     state     <= FINISH;
                  end else begin
                     // The most negative value negates to itself, which reads as 2^(RW-1) unsigned.
                     sign  <= ~op & Data[RW-1];
                     mag   <= (~op & Data[RW-1]) ? -Data : Data;
                     state <= CONVERT;
                  end
               end
            end
            CONVERT: begin
               work_bcd <= {adj_bcd[BW-2:0], mag[RW-1]};
               mag      <= {mag[RW-2:0], 1'b0};
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(RW - 1)) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               BCD       <= final_bcd;
               error_out <= err_cap;
               done      <= 1'b1;
               valid     <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
